// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector: run-time pattern/length, optional
// overlapping matches, valid-qualified input and a saturating match counter.
module seq_det_prog #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             armed,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_err
);

  typedef enum logic {
    UNCFG  = 1'b0,
    SEARCH = 1'b1
  } state_t;

  localparam logic [31:0]      PAT_W_U = PAT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;

  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic             ovl;
  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;

  logic             cfg_legal;
  logic             sample;
  logic [PAT_W-1:0] hist_nxt;
  logic [LEN_W-1:0] fill_nxt;
  logic [PAT_W-1:0] len_mask;
  logic             hit;

  // State register
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state <= UNCFG;
    else      state <= state_nxt;
  end

  // Next-state logic: only a legal load moves the FSM
  always_comb begin
    state_nxt = state;
    if (cfg_load && cfg_legal) state_nxt = SEARCH;
  end

  // Output decode from registered state only
  always_comb begin
    armed = 1'b0;
    if (state == SEARCH) armed = 1'b1;
  end

  // Sample path; a load in the same cycle always discards the sample
  always_comb begin
    cfg_legal = (cfg_len != '0) && (32'(cfg_len) <= PAT_W_U);
    sample    = (state == SEARCH) && in_valid && !cfg_load;
    hist_nxt  = {hist[PAT_W-2:0], in};
    fill_nxt  = (32'(fill) >= PAT_W_U) ? fill : fill + LEN_W'(1);
    len_mask  = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < 32'(len));
    end
    hit = sample && (fill_nxt >= len) &&
          ((hist_nxt & len_mask) == (pat & len_mask));
  end

  // Configuration, history, pulses and counter
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      pat         <= '0;
      len         <= '0;
      ovl         <= 1'b0;
      hist        <= '0;
      fill        <= '0;
      match       <= 1'b0;
      cfg_err     <= 1'b0;
      match_count <= '0;
    end else begin
      match   <= hit;
      cfg_err <= cfg_load && !cfg_legal;

      if (cfg_load && cfg_legal) begin
        pat  <= cfg_pattern;
        len  <= cfg_len;
        ovl  <= cfg_overlap;
        hist <= '0;
        fill <= '0;
      end else if (sample) begin
        hist <= hist_nxt;
        // Non-overlap restarts the fill so the next hit needs len fresh samples
        fill <= (hit && !ovl) ? '0 : fill_nxt;
      end

      if (cnt_clr) begin
        match_count <= '0;
      end else if (hit && (match_count != CNT_MAX)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: directed scenarios plus random traffic, checked
// against a queue-based reference model; two DUTs differ only in CNT_W.
module tb_seq_det_prog;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             in_valid = 1'b0;
  logic             din = 1'b0;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic             cnt_clr = 1'b0;

  logic        armed0, match0, err0;
  logic [15:0] cnt0;
  logic        armed1, match1, err1;
  logic [1:0]  cnt1;

  seq_det_prog #(.PAT_W(8), .CNT_W(16)) u0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in(din),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .armed(armed0), .match(match0), .match_count(cnt0), .cfg_err(err0)
  );

  seq_det_prog #(.PAT_W(8), .CNT_W(2)) u1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in(din),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .armed(armed1), .match(match1), .match_count(cnt1), .cfg_err(err1)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  bit chk_en = 1'b0;

  // Reference model: configuration plus the queue of samples since the last restart
  bit         m_cfg;
  bit [7:0]   m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_q[$];
  bit         exp_armed, exp_match, exp_err;
  int         exp_c0, exp_c1;

  task automatic model_reset();
    m_cfg = 0; m_pat = '0; m_len = 0; m_ovl = 0; m_q.delete();
    exp_armed = 0; exp_match = 0; exp_err = 0; exp_c0 = 0; exp_c1 = 0;
  endtask

  task automatic model_edge();
    bit hit;
    hit = 0;
    if (rstn) begin
      model_reset();
      return;
    end
    exp_err = 0;
    if (cfg_load) begin
      if (cfg_len >= 1 && cfg_len <= PAT_W) begin
        m_cfg = 1; m_pat = cfg_pattern; m_len = int'(cfg_len);
        m_ovl = cfg_overlap; m_q.delete();
      end else begin
        exp_err = 1;
      end
    end else if (m_cfg && in_valid) begin
      m_q.push_back(din);
      if (m_q.size() > PAT_W) void'(m_q.pop_front());
      if (m_q.size() >= m_len) begin
        hit = 1;
        for (int k = 0; k < m_len; k++)
          if (m_q[m_q.size() - 1 - k] != m_pat[k]) hit = 0;
      end
      if (hit && !m_ovl) m_q.delete();
    end
    exp_match = hit;
    if (cnt_clr) begin
      exp_c0 = 0; exp_c1 = 0;
    end else if (hit) begin
      if (exp_c0 < 65535) exp_c0++;
      if (exp_c1 < 3) exp_c1++;
    end
    exp_armed = m_cfg;
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("armed0", int'(armed0), int'(exp_armed));
      cmp("match0", int'(match0), int'(exp_match));
      cmp("cnt0",   int'(cnt0),   exp_c0);
      cmp("err0",   int'(err0),   int'(exp_err));
      cmp("armed1", int'(armed1), int'(exp_armed));
      cmp("match1", int'(match1), int'(exp_match));
      cmp("cnt1",   int'(cnt1),   exp_c1);
      cmp("err1",   int'(err1),   int'(exp_err));
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 0; cfg_load = 0; cnt_clr = 0;
    repeat (n) step();
  endtask

  task automatic send(input bit b);
    in_valid = 1; din = b; cfg_load = 0; cnt_clr = 0;
    step();
    in_valid = 0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
    cfg_load = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    in_valid = 0; cnt_clr = 0;
    step();
    cfg_load = 0;
  endtask

  task automatic clear();
    cnt_clr = 1; in_valid = 0; cfg_load = 0;
    step();
    cnt_clr = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s1[] = '{1,0,1,1,0,1,1};
    bit s2[] = '{1,0,1,1,1,0,1,1};
    model_reset();
    chk_en = 1;
    idle(2);
    cmp("rst_armed", int'(armed0), 0);
    cmp("rst_cnt",   int'(cnt0),   0);
    rstn = 0;
    idle(1);
    send(1);
    cmp("uncfg_ignores", int'(match0), 0);

    // Overlapping 1011 over 1011011: hits after 4th and 7th samples
    load(8'b1011, 4'd4, 1'b1);
    cmp("armed_after_load", int'(armed0), 1);
    foreach (s1[i]) begin
      send(s1[i]);
      if (i == 3) cmp("ovl_hit1", int'(match0), 1);
    end
    cmp("ovl_hit2", int'(match0), 1);
    cmp("ovl_count", int'(cnt0), 2);
    idle(1);

    // Non-overlapping
    clear();
    load(8'b1011, 4'd4, 1'b0);
    foreach (s1[i]) send(s1[i]);
    cmp("novl_count1", int'(cnt0), 1);
    clear();
    load(8'b1011, 4'd4, 1'b0);
    foreach (s2[i]) send(s2[i]);
    cmp("novl_hit", int'(match0), 1);
    cmp("novl_count2", int'(cnt0), 2);

    // Gaps of three idle cycles between bits
    clear();
    load(8'b1011, 4'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send(s1[i]);
      if (i == 3) cmp("gap_hit", int'(match0), 1);
      idle(3);
    end
    cmp("gap_count", int'(cnt0), 1);

    // Illegal loads keep the 1011 search alive
    load(8'hFF, 4'd0, 1'b0);
    cmp("err_len0", int'(err0), 1);
    cmp("err_armed", int'(armed0), 1);
    load(8'hFF, 4'd9, 1'b0);
    cmp("err_len9", int'(err0), 1);
    idle(1);
    cmp("err_pulse", int'(err0), 0);
    send(1); send(0); send(1); send(1);
    cmp("after_err_hit", int'(match0), 1);

    // len=1 and saturation on the 2-bit counter
    clear();
    load(8'h01, 4'd1, 1'b0);
    repeat (6) send(1);
    cmp("sat_cnt1", int'(cnt1), 3);
    cmp("sat_cnt0", int'(cnt0), 6);
    cnt_clr = 1; in_valid = 1; din = 1;
    step();
    cnt_clr = 0; in_valid = 0;
    cmp("clr_hit_match", int'(match0), 1);
    cmp("clr_hit_cnt", int'(cnt0), 0);

    // Asynchronous reset mid-pattern
    load(8'b1011, 4'd4, 1'b1);
    send(1); send(0); send(1);
    #1 rstn = 1;
    #1;
    cmp("arst_armed", int'(armed0), 0);
    cmp("arst_match", int'(match0), 0);
    cmp("arst_cnt",   int'(cnt0),   0);
    model_reset();
    idle(1);
    rstn = 0;
    send(1);
    cmp("arst_nomatch", int'(match0), 0);
    cmp("arst_unarmed", int'(armed0), 0);

    // Random traffic
    load(8'b0110, 4'd3, 1'b1);
    for (int n = 0; n < 4000; n++) begin
      cfg_load = ($urandom_range(0, 99) == 0);
      cfg_pattern = 8'($urandom);
      cfg_overlap = 1'($urandom);
      if ($urandom_range(0, 7) == 0) cfg_len = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
      else cfg_len = 4'($urandom_range(1, 5));
      in_valid = ($urandom_range(0, 3) != 0);
      din = 1'($urandom);
      cnt_clr = ($urandom_range(0, 299) == 0);
      step();
    end
    cfg_load = 0; in_valid = 0; cnt_clr = 0;
    idle(2);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
Programmable serial pattern detector for single-bit streams, generalising the fixed four-bit detector FSM. It has a run-time pattern and length up to PAT_W bits, selectable overlapping or non-overlapping matching, a valid qualifier on the input stream, and a saturating match counter. It sits on a serial monitor path, and the UVM bench drives it directly.

Parameters:
PAT_W, 8, maximum pattern length in bits (legal range 2..32)
CNT_W, 16, width of match_count
LEN_W, $clog2(PAT_W+1), width of cfg_len (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous reset, active-high (1 = reset asserted)
in_valid  input  1  qualifies in; a sample is taken only when in_valid=1
in  input  1  serial data bit
cfg_load  input  1  one-cycle strobe; latch cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  input  PAT_W  pattern; bit [cfg_len-1] is the first bit expected, bit 0 the last
cfg_len  input  LEN_W  pattern length, legal 1..PAT_W
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = restart after a match
cnt_clr  input  1  synchronous clear of match_count
armed  output  1  a legal configuration is loaded and the detector is searching
match  output  1  one-cycle pulse per detected pattern
match_count  output  CNT_W  number of matches since reset or clear, saturating
cfg_err  output  1  one-cycle pulse when a cfg_load is rejected

Behaviour:
- Reset (rstn=1, asynchronous): state=UNCFG. History, fill counter and latched config are all zero. armed=0, match=0, match_count=0, cfg_err=0. Deassertion is synchronised by the user; the block needs no internal synchroniser.
- States:
  - UNCFG: samples are ignored. On a legal cfg_load, go to SEARCH.
  - SEARCH: detecting.
  - A legal cfg_load in SEARCH re-enters SEARCH with the new configuration.
  - An illegal cfg_load (cfg_len=0 or cfg_len>PAT_W) leaves the state, configuration and history unchanged, and pulses cfg_err=1 in the next cycle.
- armed=1 exactly when state=SEARCH (registered).
- Legal cfg_load: latches all three config fields, clears the history register and fill counter, and forces match=0 in the next cycle.
- cfg_load and in_valid in the same cycle: the load wins and the sample is discarded.
- Sample handling in SEARCH, when in_valid=1:
  - hist <= {hist[PAT_W-2:0], in}
  - fill <= min(fill+1, PAT_W)
- When in_valid=0, history and fill hold. Gaps in the stream never break a partial match.
- Hit condition is evaluated on the post-shift values: fill_next >= len and hist_next[len-1:0] == pat[len-1:0], with bits above len masked.
- match is registered. It goes to 1 in the cycle after the clock edge that samples the final pattern bit, and lasts exactly one cycle (1-cycle latency, same timing as the fixed detector's Moore output).
- Overlap mode 1: after a hit, history and fill continue, so a suffix of the pattern can start the next match. Example: 1011 in stream 1011011 gives two hits.
- Overlap mode 0: a hit sets fill to 0 (history content is don't-care), so the next match needs len fresh samples.
- match_count:
  - Increments by 1 on every match pulse.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr=1 sets it to 0 next cycle. If cnt_clr coincides with a hit, the clear wins: the count is 0 and that match is not counted, but the match pulse is still issued.
- len=1 is legal: every sample equal to pat[0] produces a hit, in both modes.
- Config changes take effect only via cfg_load. cfg_* inputs are ignored at all other times.
- No combinational path exists from any input to any output.

Test Plan:
- Reset, load pat=4'b1011 (len=4, overlap=1), drive 1,0,1,1,0,1,1 on consecutive cycles -> match pulses 1 cycle after the 4th and 7th samples; match_count=2; armed=1 from the cycle after the load.
- Same stream with overlap=0 -> single match after the 4th sample, count=1. Stream 1,0,1,1,1,0,1,1 -> matches after the 4th and 8th samples, count=2.
- pat=1011 with in_valid=0 gaps of 3 cycles between every bit -> match 1 cycle after the final valid sample; idle cycles neither break nor produce matches.
- Illegal loads: cfg_len=0, then cfg_len=PAT_W+1 -> cfg_err pulses each time; armed and config are unchanged; a prior 1011 search still matches.
- CNT_W=2, pat=1 (len=1), 6 consecutive ones -> count goes 1,2,3,3,3,3. cnt_clr coincident with a hit -> match=1, count=0.
- Assert rstn for 1 cycle after 3 samples of 1011 -> all outputs are 0 immediately (asynchronously) and state=UNCFG. A 4th sample of 1 produces no match until a reload.
